tpg_source: RTL and testbench

//  Traffic pattern generator: the transmit end of the packet format consumed by the NoC traffic sink.

---
 rtl/tpg_source.sv | 139 +++++++++++++
 tb/tb_tpg_source.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpg_source.sv
// Traffic pattern generator: builds {src,dst,id,data} packets and drives them
// into a router port over valid/ready, optionally bounded and rate-limited.
module tpg_source #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 0,
    parameter int DEST_MODE    = 0,
    parameter int DEST         = 15,
    parameter int NUM_PKTS     = 100,
    parameter int GAP          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             done,
    output logic [15:0]      sent_count
);

    localparam int DW = WIDTH - 2*N_ADDR_WIDTH - 8;
    localparam logic [N_ADDR_WIDTH-1:0] SRC       = N_ADDR_WIDTH'(NODE);
    localparam logic [N_ADDR_WIDTH-1:0] LAST_NODE = N_ADDR_WIDTH'(N - 1);
    localparam logic [N_ADDR_WIDTH-1:0] DST_INIT  =
        (DEST_MODE == 0) ? N_ADDR_WIDTH'(DEST) : N_ADDR_WIDTH'((NODE + 1) % N);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t                  state;
    logic [N_ADDR_WIDTH-1:0] dst;
    logic [7:0]              id;
    logic [DW-1:0]           data_ctr;
    logic [31:0]             pkt_cnt;
    logic [31:0]             gap_cnt;

    logic [N_ADDR_WIDTH-1:0] dst_nx;
    logic [7:0]              id_nx;
    logic [DW-1:0]           data_nx;
    logic                    last_pkt;

    function automatic logic [N_ADDR_WIDTH-1:0] bump_dst(input logic [N_ADDR_WIDTH-1:0] d);
        return (d == LAST_NODE) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] pack(input logic [N_ADDR_WIDTH-1:0] d,
                                              input logic [7:0] i,
                                              input logic [DW-1:0] c);
        return {SRC, d, i, c};
    endfunction

    // Field values for the packet after the one currently being accepted.
    always_comb begin
        dst_nx  = dst;
        id_nx   = id + 8'd1;
        data_nx = data_ctr + DW'(1);
        if (DEST_MODE != 0) begin
            dst_nx = bump_dst(dst);
            if (dst_nx == SRC) begin
                dst_nx = bump_dst(dst_nx);
            end
        end
        last_pkt = (NUM_PKTS != 0) && ((pkt_cnt + 32'd1) == 32'(NUM_PKTS));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            valid_out  <= 1'b0;
            data_out   <= '0;
            done       <= 1'b0;
            sent_count <= '0;
            dst        <= DST_INIT;
            id         <= '0;
            data_ctr   <= '0;
            pkt_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_SEND;
                        valid_out <= 1'b1;
                        data_out  <= pack(dst, id, data_ctr);
                    end
                end
                // valid_out is always high here; only acceptance moves us on.
                S_SEND: begin
                    if (ready_in) begin
                        dst      <= dst_nx;
                        id       <= id_nx;
                        data_ctr <= data_nx;
                        pkt_cnt  <= pkt_cnt + 32'd1;
                        if (sent_count != 16'hFFFF) begin
                            sent_count <= sent_count + 16'd1;
                        end
                        if (last_pkt) begin
                            state     <= S_DONE;
                            valid_out <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP > 0) begin
                            state     <= S_GAP;
                            valid_out <= 1'b0;
                            gap_cnt   <= '0;
                        end else if (enable) begin
                            data_out  <= pack(dst_nx, id_nx, data_nx);
                        end else begin
                            state     <= S_IDLE;
                            valid_out <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 32'(GAP - 1)) begin
                        if (enable) begin
                            state     <= S_SEND;
                            valid_out <= 1'b1;
                            data_out  <= pack(dst, id, data_ctr);
                        end else begin
                            state     <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    valid_out <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpg_source.sv
// Bench for tpg_source: a bounded fixed-destination source and an unlimited
// round-robin source with gaps, checked against a packet-sequence model.
module tb_tpg_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_a, ready_a, enable_b, ready_b;
    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b, done_a, done_b;
    logic [15:0] sent_a, sent_b;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int          dst_list[$];
    int          b_pushed = 0;
    logic [31:0] last_b   = '0;

    logic        pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0, prst = 1'b0;
    logic [31:0] pd_a = '0, pd_b = '0;

    bit          pat_en[9]    = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit          pat_valid[9] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};

    tpg_source #(
        .WIDTH(32), .N(16), .NODE(3), .DEST_MODE(0), .DEST(15), .NUM_PKTS(4), .GAP(0)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable_a), .data_out(data_a),
        .valid_out(valid_a), .ready_in(ready_a), .done(done_a), .sent_count(sent_a)
    );

    tpg_source #(
        .WIDTH(32), .N(4), .NODE(2), .DEST_MODE(1), .DEST(0), .NUM_PKTS(0), .GAP(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .data_out(data_b),
        .valid_out(valid_b), .ready_in(ready_b), .done(done_b), .sent_count(sent_b)
    );

    always #5 clk = ~clk;

    // The k-th accepted packet since reset, straight from the packet format.
    function automatic logic [31:0] model_a(input int k);
        return {4'd3, 4'd15, 8'(k), 16'(k)};
    endfunction

    function automatic logic [31:0] model_b(input int k);
        int d;
        d = dst_list[k % dst_list.size()];
        return {2'd2, 2'(d), 8'(k), 20'(k)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: actual=0x%h required=0x%h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic r, input logic ea, input logic ra,
                                 input logic eb, input logic rb);
        rst      = r;
        enable_a = ea;
        ready_a  = ra;
        enable_b = eb;
        ready_b  = rb;
        @(posedge clk);
        #1;
    endtask

    task automatic resetModels();
        exp_a.delete();
        exp_b.delete();
        b_pushed = 0;
    endtask

    task automatic pushB(input int count);
        repeat (count) begin
            exp_b.push_back(model_b(b_pushed));
            b_pushed++;
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (prst && pv_a && !pr_a) begin
                checkOutput("a_hold_valid", {31'd0, valid_a}, 32'd1);
                checkOutput("a_hold_data", data_a, pd_a);
            end
            if (prst && pv_b && !pr_b) begin
                checkOutput("b_hold_valid", {31'd0, valid_b}, 32'd1);
                checkOutput("b_hold_data", data_b, pd_b);
            end
            if (rst === 1'b1 && valid_a === 1'b1 && ready_a === 1'b1) begin
                if (exp_a.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL a_unexpected_pkt: actual=0x%h required=no packet", data_a);
                end else begin
                    checkOutput("a_pkt", data_a, exp_a.pop_front());
                end
            end
            if (rst === 1'b1 && valid_b === 1'b1 && ready_b === 1'b1) begin
                last_b = data_b;
                if (exp_b.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL b_unexpected_pkt: actual=0x%h required=no packet", data_b);
                end else begin
                    checkOutput("b_pkt", data_b, exp_b.pop_front());
                end
            end
            pv_a = valid_a; pr_a = ready_a; pd_a = data_a;
            pv_b = valid_b; pr_b = ready_b; pd_b = data_b;
            prst = rst;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int j = 1; j < 4; j++) dst_list.push_back((2 + j) % 4);

        // Held in reset with enable and ready high: nothing may come out.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            checkOutput("rst_valid_a", {31'd0, valid_a}, 32'd0);
            checkOutput("rst_data_a", data_a, 32'd0);
            checkOutput("rst_done_a", {31'd0, done_a}, 32'd0);
            checkOutput("rst_sent_a", {16'd0, sent_a}, 32'd0);
            checkOutput("rst_valid_b", {31'd0, valid_b}, 32'd0);
        end
        resetModels();

        // Sustained burst of NUM_PKTS packets, one per cycle.
        for (int k = 0; k < 4; k++) exp_a.push_back(model_a(k));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput("a_burst_valid", {31'd0, valid_a}, 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("a_end_valid", {31'd0, valid_a}, 32'd0);
        checkOutput("a_end_done", {31'd0, done_a}, 32'd1);
        checkOutput("a_end_sent", {16'd0, sent_a}, 32'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("a_done_sticky", {31'd0, done_a}, 32'd1);
        checkOutput("a_done_quiet", {31'd0, valid_a}, 32'd0);
        checkOutput("a_burst_drained", 32'(exp_a.size()), 32'd0);

        // Backpressure on id=1: held stable, then accepted exactly once.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        resetModels();
        checkOutput("a_rst_done", {31'd0, done_a}, 32'd0);
        checkOutput("a_rst_sent", {16'd0, sent_a}, 32'd0);
        for (int k = 0; k < 4; k++) exp_a.push_back(model_a(k));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("a_pending_pkt", data_a, model_a(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput("a_stall_valid", {31'd0, valid_a}, 32'd1);
            checkOutput("a_stall_data", data_a, model_a(1));
        end
        for (int c = 0; c < 20 && done_a !== 1'b1; c++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("a_stall_done", {31'd0, done_a}, 32'd1);
        checkOutput("a_stall_sent", {16'd0, sent_a}, 32'd4);
        checkOutput("a_stall_drained", 32'(exp_a.size()), 32'd0);

        // Random enable/ready on the bounded source.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        resetModels();
        for (int k = 0; k < 4; k++) exp_a.push_back(model_a(k));
        for (int c = 0; c < 400 && done_a !== 1'b1; c++)
            applyStimulus(1'b1, ($urandom % 4) != 0, ($urandom % 2) == 1, 1'b0, 1'b1);
        checkOutput("a_rand_done", {31'd0, done_a}, 32'd1);
        checkOutput("a_rand_sent", {16'd0, sent_a}, 32'd4);
        checkOutput("a_rand_drained", 32'(exp_a.size()), 32'd0);

        // Gap pacing, then enable dropped during the gap.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        resetModels();
        pushB(2);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, pat_en[i], 1'b1);
            checkOutput("b_gap_valid", {31'd0, valid_b}, {31'd0, pat_valid[i]});
        end
        checkOutput("b_gap_sent", {16'd0, sent_b}, 32'd2);
        checkOutput("b_gap_drained", 32'(exp_b.size()), 32'd0);

        // Long random run: round-robin dst and id wrap past 255.
        pushB(255);
        for (int c = 0; c < 3000 && sent_b < 16'd257; c++)
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, ($urandom % 4) != 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("b_long_sent", {16'd0, sent_b}, 32'd257);
        checkOutput("b_long_idle", {31'd0, valid_b}, 32'd0);
        checkOutput("b_long_drained", 32'(exp_b.size()), 32'd0);
        checkOutput("b_wrap_id", {24'd0, last_b[27:20]}, 32'd0);
        checkOutput("b_wrap_data", {12'd0, last_b[19:0]}, 32'd256);
        checkOutput("b_wrap_dst", {30'd0, last_b[29:28]}, 32'd0);
        checkOutput("b_never_done", {31'd0, done_b}, 32'd0);

        // Reset while a packet is pending drops it.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b_pend_valid", {31'd0, valid_b}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("b_midrst_valid", {31'd0, valid_b}, 32'd0);
        checkOutput("b_midrst_sent", {16'd0, sent_b}, 32'd0);
        resetModels();
        pushB(1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("b_post_rst_pkt", data_b, {2'd2, 2'd3, 8'd0, 20'd0});
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("b_post_rst_sent", {16'd0, sent_b}, 32'd1);
        checkOutput("b_post_rst_drained", 32'(exp_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
